// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// The fetch unit is the master: it raises a request with an address and waits for ready.
interface if_fetch_unit_if;
   logic        Imem_Req;
   logic [31:0] Imem_Addr;
   logic        Imem_Ready;
   logic [31:0] Imem_Data;

   modport master (
      output Imem_Req,
      output Imem_Addr,
      input  Imem_Ready,
      input  Imem_Data
   );

   modport slave (
      input  Imem_Req,
      input  Imem_Addr,
      output Imem_Ready,
      output Imem_Data
   );
endinterface

// File: rtl/if_fetch_unit.sv
// IF stage: fetches one instruction at a time from imem, holds it for IF/ID,
// and handles branch/jump redirects, including draining an in-flight request.
module if_fetch_unit (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Pc_Write,
   input  logic                  Branch_Taken,
   input  logic [31:0]           Branch_Target,
   input  logic                  Jump,
   input  logic [25:0]           Jump_Index,
   input  logic [31:0]           Id_add0_in,
   if_fetch_unit_if.master       imem,
   output logic [31:0]           If_add0_out,
   output logic [31:0]           If_Instruction_out,
   output logic                  If_Valid,
   output logic                  If_Id_Write_out,
   output logic                  If_Id_Flush_out
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] instr_buf, instr_nxt;
   logic [31:0] add0_buf, add0_nxt;
   logic [31:0] drain_addr, drain_nxt;
   logic        valid, valid_nxt;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        unused_bits;

   assign redirect    = Branch_Taken | Jump;
   assign target      = Branch_Taken ? {Branch_Target[31:2], 2'b00}
                                     : {Id_add0_in[31:28], Jump_Index, 2'b00};
   assign pc_plus4    = pc + 32'd4;
   assign unused_bits = ^{Branch_Target[1:0], Id_add0_in[27:0]};

   // DRAIN keeps presenting the abandoned address, since pc already holds the new target
   assign imem.Imem_Req    = ~rst & (state != HOLD);
   assign imem.Imem_Addr   = (state == DRAIN) ? drain_addr : pc;
   assign If_add0_out        = add0_buf;
   assign If_Instruction_out = instr_buf;
   assign If_Valid           = valid;
   assign If_Id_Write_out    = valid & Pc_Write;
   assign If_Id_Flush_out    = ~rst & redirect;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      instr_nxt = instr_buf;
      add0_nxt  = add0_buf;
      drain_nxt = drain_addr;
      valid_nxt = valid;
      case (state)
         FETCH: begin
            if (redirect) begin
               pc_nxt    = target;
               valid_nxt = 1'b0;
               if (imem.Imem_Ready) begin
                  state_nxt = FETCH;
               end else begin
                  state_nxt = DRAIN;
                  drain_nxt = pc;
               end
            end else if (imem.Imem_Ready) begin
               instr_nxt = imem.Imem_Data;
               add0_nxt  = pc_plus4;
               valid_nxt = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_nxt    = target;
               valid_nxt = 1'b0;
               state_nxt = FETCH;
            end else if (Pc_Write) begin
               pc_nxt    = pc_plus4;
               valid_nxt = 1'b0;
               state_nxt = FETCH;
            end
         end
         DRAIN: begin
            // The returning word belongs to the squashed path and is dropped
            if (redirect) begin
               pc_nxt = target;
            end
            if (imem.Imem_Ready) begin
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FETCH;
         pc         <= 32'd0;
         instr_buf  <= 32'd0;
         add0_buf   <= 32'd0;
         drain_addr <= 32'd0;
         valid      <= 1'b0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         instr_buf  <= instr_nxt;
         add0_buf   <= add0_nxt;
         drain_addr <= drain_nxt;
         valid      <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, all checked
// against a flag-based reference model of the fetch/hold/squash behaviour.
module tb_if_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        pc_write;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [25:0] jump_index;
   logic [31:0] id_add0;
   logic [31:0] if_add0;
   logic [31:0] if_instr;
   logic        if_valid;
   logic        if_id_write;
   logic        if_id_flush;

   if_fetch_unit_if bus ();

   if_fetch_unit dut (
      .clk                (clk),
      .rst                (rst),
      .Pc_Write           (pc_write),
      .Branch_Taken       (branch_taken),
      .Branch_Target      (branch_target),
      .Jump               (jump),
      .Jump_Index         (jump_index),
      .Id_add0_in         (id_add0),
      .imem               (bus.master),
      .If_add0_out        (if_add0),
      .If_Instruction_out (if_instr),
      .If_Valid           (if_valid),
      .If_Id_Write_out    (if_id_write),
      .If_Id_Flush_out    (if_id_flush)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: m_valid means an instruction is held, m_drain means a squashed request is outstanding
   logic        m_known = 1'b0;
   logic        m_valid, m_drain;
   logic [31:0] m_pc, m_drain_addr, m_instr, m_add0;

   int          lat = 0;
   int          mem_cnt = 0;
   logic [31:0] late_word;
   logic        drained;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic pw, input logic bt,
                                input logic [31:0] btgt, input logic j,
                                input logic [25:0] ji, input logic [31:0] ida);
      rst           = r;
      pc_write      = pw;
      branch_taken  = bt;
      branch_target = btgt;
      jump          = j;
      jump_index    = ji;
      id_add0       = ida;
   endtask

   task automatic memRespond();
      if (rst || bus.Imem_Req !== 1'b1) begin
         bus.Imem_Ready = 1'b0;
         mem_cnt        = 0;
      end else if (mem_cnt >= lat) begin
         bus.Imem_Ready = 1'b1;
         bus.Imem_Data  = $urandom;
         mem_cnt        = 0;
      end else begin
         bus.Imem_Ready = 1'b0;
         mem_cnt++;
      end
   endtask

   task automatic checkOutput();
      chk("imem_req", 32'(bus.Imem_Req), 32'(!rst && !m_valid && m_known));
      chk("if_id_flush", 32'(if_id_flush), 32'(!rst && (branch_taken || jump)));
      if (m_known) begin
         chk("imem_addr", bus.Imem_Addr, m_drain ? m_drain_addr : m_pc);
         chk("if_valid", 32'(if_valid), 32'(m_valid));
         chk("if_instr", if_instr, m_instr);
         chk("if_add0", if_add0, m_add0);
         chk("if_id_write", 32'(if_id_write), 32'(m_valid && pc_write));
      end
   endtask

   task automatic modelStep();
      logic [31:0] tgt;
      tgt = branch_taken ? {branch_target[31:2], 2'b00} : {id_add0[31:28], jump_index, 2'b00};
      if (rst) begin
         m_known = 1'b1; m_valid = 1'b0; m_drain = 1'b0;
         m_pc = 32'd0; m_drain_addr = 32'd0; m_instr = 32'd0; m_add0 = 32'd0;
      end else if (m_drain) begin
         if (bus.Imem_Ready) m_drain = 1'b0;
         if (branch_taken || jump) m_pc = tgt;
      end else if (m_valid) begin
         if (branch_taken || jump) begin
            m_pc = tgt; m_valid = 1'b0;
         end else if (pc_write) begin
            m_pc = m_pc + 32'd4; m_valid = 1'b0;
         end
      end else if (branch_taken || jump) begin
         if (!bus.Imem_Ready) begin
            m_drain = 1'b1; m_drain_addr = m_pc;
         end
         m_pc = tgt;
      end else if (bus.Imem_Ready) begin
         m_instr = bus.Imem_Data; m_add0 = m_pc + 32'd4; m_valid = 1'b1;
      end
   endtask

   task automatic cycleBegin();
      #1 memRespond();
      #1 checkOutput();
   endtask

   task automatic cycleEnd();
      modelStep();
      @(negedge clk);
   endtask

   task automatic goHold();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      for (int k = 0; k < 12 && !m_valid; k++) begin
         cycleBegin();
         cycleEnd();
      end
   endtask

   initial begin
      bus.Imem_Ready = 1'b0;
      bus.Imem_Data  = 32'd0;

      // Power-up reset, then straight-line fetching with an always-ready memory
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      cycleBegin(); cycleEnd();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      for (int i = 0; i < 6; i++) begin
         cycleBegin();
         if (i % 2 == 0) begin
            chk("seq_addr", bus.Imem_Addr, 32'(i * 2));
         end else begin
            chk("seq_add0", if_add0, 32'((i + 1) * 2));
            chk("seq_write", 32'(if_id_write), 32'd1);
         end
         cycleEnd();
      end

      // Three stalled cycles while holding
      goHold();
      for (int i = 0; i < 3; i++) begin
         cycleBegin();
         chk("stall_req", 32'(bus.Imem_Req), 32'd0);
         chk("stall_write", 32'(if_id_write), 32'd0);
         cycleEnd();
      end

      // Branch in HOLD with a misaligned target
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0043, 1'b0, 26'd0, 32'd0);
      cycleBegin(); chk("branch_flush", 32'(if_id_flush), 32'd1); cycleEnd();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      cycleBegin();
      chk("branch_addr", bus.Imem_Addr, 32'h0000_0040);
      chk("branch_valid", 32'(if_valid), 32'd0);
      cycleEnd();

      // PC wrap-around at the top of the address space
      goHold();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 26'd0, 32'd0);
      cycleBegin(); cycleEnd();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      cycleBegin(); chk("wrap_addr", bus.Imem_Addr, 32'hFFFF_FFFC); cycleEnd();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      cycleBegin(); chk("wrap_add0", if_add0, 32'd0); cycleEnd();
      cycleBegin(); chk("wrap_next", bus.Imem_Addr, 32'd0); cycleEnd();

      // Jump, then a branch while that fetch is still outstanding
      goHold();
      lat = 3;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h000_0010, 32'h1000_0008);
      cycleBegin(); chk("jump_flush", 32'(if_id_flush), 32'd1); cycleEnd();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 26'd0, 32'd0);
      cycleBegin(); chk("jump_addr", bus.Imem_Addr, 32'h1000_0040); cycleEnd();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      drained   = 1'b0;
      late_word = 32'd0;
      for (int k = 0; k < 10 && !drained; k++) begin
         cycleBegin();
         chk("drain_addr", bus.Imem_Addr, 32'h1000_0040);
         if (bus.Imem_Ready) begin
            drained   = 1'b1;
            late_word = bus.Imem_Data;
         end
         cycleEnd();
      end
      chk("drain_done", 32'(drained), 32'd1);
      cycleBegin(); chk("redirect_addr", bus.Imem_Addr, 32'h0000_0080); cycleEnd();
      goHold();
      chk("late_word_hidden", 32'(if_instr == late_word), 32'd0);

      // Reset while holding and stalled, with a branch on the same cycle
      lat = 0;
      goHold();
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_1234, 1'b0, 26'd0, 32'd0);
      cycleBegin(); cycleEnd();
      cycleBegin();
      chk("rst_addr", bus.Imem_Addr, 32'd0);
      chk("rst_instr", if_instr, 32'd0);
      chk("rst_add0", if_add0, 32'd0);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_req", 32'(bus.Imem_Req), 32'd0);
      chk("rst_flush", 32'(if_id_flush), 32'd0);
      cycleEnd();
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0);
      cycleBegin();
      chk("post_rst_addr", bus.Imem_Addr, 32'd0);
      chk("post_rst_req", 32'(bus.Imem_Req), 32'd1);
      cycleEnd();

      // Random traffic: stalls, redirects, variable memory latency, occasional reset
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 40) == 0, ($urandom % 4) != 0, ($urandom % 8) == 0,
                       $urandom, ($urandom % 8) == 0, 26'($urandom), $urandom);
         if (($urandom % 16) == 0) lat = $urandom_range(0, 3);
         cycleBegin();
         cycleEnd();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port Pc_Write, input, 1 bit: hazard-unit permit to advance; 0 means stall.
REQ-004 SHALL have port Branch_Taken, input, 1 bit: branch resolved taken in ID.
REQ-005 SHALL have port Branch_Target, input, 32 bits: branch destination.
REQ-006 SHALL have port Jump, input, 1 bit: J-type instruction in ID.
REQ-007 SHALL have port Jump_Index, input, 26 bits: instr[25:0] of the jump.
REQ-008 SHALL have port Id_add0_in, input, 32 bits: PC+4 of the ID-stage instruction.
REQ-009 SHALL have port Imem_Req, output, 1 bit: instruction-memory request.
REQ-010 SHALL have port Imem_Addr, output, 32 bits: fetch address.
REQ-011 SHALL have port Imem_Ready, input, 1 bit: Imem_Data valid; completes the request.
REQ-012 SHALL have port Imem_Data, input, 32 bits: instruction word.
REQ-013 SHALL have port If_add0_out, output, 32 bits: PC+4 of the held instruction; feeds If_Id_add0_in.
REQ-014 SHALL have port If_Instruction_out, output, 32 bits: held instruction; feeds If_Id_Instruction_in.
REQ-015 SHALL have port If_Valid, output, 1 bit: held instruction is valid.
REQ-016 SHALL have port If_Id_Write_out, output, 1 bit: equals If_Valid & Pc_Write; drives If_Id_Write.
REQ-017 SHALL have port If_Id_Flush_out, output, 1 bit: combinational redirect indication; drives If_Id_Flush.

Function
REQ-018 SHALL implement the states FETCH, HOLD and DRAIN, plus the 32-bit registers PC, instruction buffer and add0 buffer.
REQ-019 SHALL, in FETCH, drive Imem_Req=1 and Imem_Addr=PC, holding both stable until Imem_Ready is seen.
REQ-020 SHALL, in FETCH with Imem_Ready=1 and no redirect: load the instruction buffer with Imem_Data and the add0 buffer with PC+4, set If_Valid=1 on the next cycle, and go to HOLD.
REQ-021 SHALL, in HOLD, drive Imem_Req=0; with Pc_Write=1 and no redirect: PC<=PC+4, If_Valid<=0, go to FETCH; with Pc_Write=0: hold all registers and state.
REQ-022 SHALL treat Branch_Taken=1 or Jump=1 as a redirect; Branch_Taken takes priority when both are 1.
REQ-023 SHALL compute the jump target as {Id_add0_in[31:28], Jump_Index, 2'b00}, and force the branch target to {Branch_Target[31:2], 2'b00}.
REQ-024 SHALL, on a redirect in any state: load PC with the target, set If_Valid<=0, and assert If_Id_Flush_out in that same cycle.
REQ-025 SHALL apply a redirect regardless of Pc_Write (redirect overrides stall).
REQ-026 SHALL, on a redirect in HOLD, or in FETCH coinciding with Imem_Ready=1, discard any returned data and go to FETCH.
REQ-027 SHALL, on a redirect in FETCH with Imem_Ready=0, go to DRAIN.
REQ-028 SHALL, in DRAIN, keep Imem_Req=1 with the old address until Imem_Ready=1, discard that word, then go to FETCH.
REQ-029 SHALL, on a further redirect during DRAIN, overwrite PC with the newest target and remain in DRAIN.
REQ-030 SHALL perform PC+4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-031 SHALL keep If_add0_out and If_Instruction_out unchanged whenever If_Valid=0, except at reset.

Reset
REQ-032 SHALL, while rst=1, on each clock set PC, both buffers and If_Valid to 0, and the state to FETCH; rst overrides any redirect, stall or Imem_Ready.
REQ-033 SHALL drive Imem_Req=0 and If_Id_Flush_out=0 while rst=1.
REQ-034 SHALL abandon any outstanding request when rst is asserted mid-operation; instruction memory shares rst and drops it too.
REQ-035 SHALL request address 0x00000000 in the first cycle after rst deasserts.

Verification
REQ-036 SHALL cover: rst one cycle, Imem_Ready=1 always, Pc_Write=1 -> Imem_Addr 0,4,8 on alternate cycles; If_add0_out 4,8,12 paired with the matching data; If_Id_Write_out pulses once per fetch.
REQ-037 SHALL cover: Pc_Write=0 for 3 cycles in HOLD -> outputs, PC and state frozen, Imem_Req=0, If_Id_Write_out=0.
REQ-038 SHALL cover: Branch_Taken=1, Branch_Target=0x00000043 in HOLD -> If_Id_Flush_out=1 that cycle, next cycle Imem_Addr=0x00000040 with If_Valid=0.
REQ-039 SHALL cover: Jump=1, Id_add0_in=0x10000008, Jump_Index=0x0000010 -> next fetch address 0x10000040.
REQ-040 SHALL cover: redirect to 0x80 in FETCH with Imem_Ready delayed 3 cycles -> DRAIN, Imem_Addr held at the old value, late word never appears on If_Instruction_out, then Imem_Addr=0x80.
REQ-041 SHALL cover: rst=1 in HOLD with Pc_Write=0 and Branch_Taken=1 -> next cycle all outputs 0; first post-reset Imem_Addr=0x00000000.
